// File: rtl/rgb2binary_pipe.sv
// rtl/rgb2binary_pipe.sv - 3-stage RGB to gray to binary converter; RGB2BIN_COUNT_EN adds a per-frame white-pixel counter
module rgb2binary_pipe #(
  parameter int DW    = 8,
  parameter int W_R   = 77,
  parameter int W_G   = 150,
  parameter int W_B   = 29,
  parameter int CNT_W = 20
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_DE,
  input  logic             IN_HS,
  input  logic             IN_VS,
  input  logic [DW-1:0]    IN_R,
  input  logic [DW-1:0]    IN_G,
  input  logic [DW-1:0]    IN_B,
  input  logic [DW-1:0]    THRESHOLD_LO,
  input  logic [DW-1:0]    THRESHOLD_HI,
  input  logic [1:0]       MODE,
  output logic             OUT_DE,
  output logic             OUT_HS,
  output logic             OUT_VS,
  output logic [3*DW-1:0]  OUT_GRAY,
  output logic             OUT_FLAG,
  output logic [3*DW-1:0]  OUT_BINARY,
  output logic [CNT_W-1:0] WHITE_COUNT,
  output logic             COUNT_VALID
);

  localparam int PW = DW + 8;
  localparam int SW = DW + 10;

  // stage 1: weighted channels
  logic [PW-1:0] p_r, p_g, p_b;
  logic          s1_de, s1_hs, s1_vs;
  // stage 2: gray value
  logic [DW-1:0] s2_gray;
  logic          s2_de, s2_hs, s2_vs;
  // frame-stable classification settings
  logic [1:0]    shadow_mode;
  logic [DW-1:0] shadow_lo, shadow_hi;
  logic          load_pending;

  logic [SW-1:0] sum;
  logic [DW+1:0] gray_full;
  logic [DW-1:0] gray_sat;
  logic          flag;
  logic          vs_rise_in;

  assign vs_rise_in = IN_VS & ~s1_vs;

  // stage 1: multiply each channel by its Q0.8 luma weight
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      p_r   <= '0;
      p_g   <= '0;
      p_b   <= '0;
      s1_de <= 1'b0;
      s1_hs <= 1'b0;
      s1_vs <= 1'b0;
    end else begin
      p_r   <= PW'(IN_R) * PW'(W_R);
      p_g   <= PW'(IN_G) * PW'(W_G);
      p_b   <= PW'(IN_B) * PW'(W_B);
      s1_de <= IN_DE;
      s1_hs <= IN_HS;
      s1_vs <= IN_VS;
    end
  end

  // rounded sum of weighted channels, scaled back to DW bits with saturation
  always_comb begin
    sum       = SW'(p_r) + SW'(p_g) + SW'(p_b) + SW'(128);
    gray_full = sum[SW-1:8];
    gray_sat  = gray_full[DW-1:0];
    if (|gray_full[DW+1:DW]) gray_sat = '1;
  end

  // stage 2: register gray value and syncs
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s2_gray <= '0;
      s2_de   <= 1'b0;
      s2_hs   <= 1'b0;
      s2_vs   <= 1'b0;
    end else begin
      s2_gray <= gray_sat;
      s2_de   <= s1_de;
      s2_hs   <= s1_hs;
      s2_vs   <= s1_vs;
    end
  end

  // shadow settings: load once after reset, then only at each input VS rise
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      shadow_mode  <= 2'd0;
      shadow_lo    <= '0;
      shadow_hi    <= '0;
      load_pending <= 1'b1;
    end else begin
      if (load_pending || vs_rise_in) begin
        shadow_mode <= MODE;
        shadow_lo   <= THRESHOLD_LO;
        shadow_hi   <= THRESHOLD_HI;
      end
      load_pending <= 1'b0;
    end
  end

  // threshold classification; an inverted band (lo > hi) never matches
  always_comb begin
    flag = 1'b0;
    case (shadow_mode)
      2'd1:    flag = (s2_gray <= shadow_lo);
      2'd2:    flag = (shadow_lo <= s2_gray) && (s2_gray <= shadow_hi);
      default: flag = (s2_gray > shadow_lo);
    endcase
  end

  // stage 3: register outputs, blanked while DE is low
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      OUT_DE     <= 1'b0;
      OUT_HS     <= 1'b0;
      OUT_VS     <= 1'b0;
      OUT_GRAY   <= '0;
      OUT_FLAG   <= 1'b0;
      OUT_BINARY <= '0;
    end else begin
      OUT_DE <= s2_de;
      OUT_HS <= s2_hs;
      OUT_VS <= s2_vs;
      if (s2_de) begin
        OUT_GRAY   <= {3{s2_gray}};
        OUT_FLAG   <= flag;
        OUT_BINARY <= (shadow_mode == 2'd3) ? {3{s2_gray}} : {(3*DW){flag}};
      end else begin
        OUT_GRAY   <= '0;
        OUT_FLAG   <= 1'b0;
        OUT_BINARY <= '0;
      end
    end
  end

`ifdef RGB2BIN_COUNT_EN
  logic [CNT_W-1:0] white_cnt;
  logic             s3_vs_rise;
  logic             white_px;

  assign s3_vs_rise = s2_vs & ~OUT_VS;
  assign white_px   = s2_de & flag;

  // per-frame white-pixel count, reported and restarted at each stage-3 VS rise
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      white_cnt   <= '0;
      WHITE_COUNT <= '0;
      COUNT_VALID <= 1'b0;
    end else begin
      COUNT_VALID <= s3_vs_rise;
      if (s3_vs_rise) begin
        WHITE_COUNT <= white_cnt;
        white_cnt   <= CNT_W'(white_px);
      end else if (white_px && (white_cnt != '1)) begin
        white_cnt <= white_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign WHITE_COUNT = '0;
  assign COUNT_VALID = 1'b0;
`endif

endmodule

// File: tb/tb_rgb2binary_pipe.sv
// tb/tb_rgb2binary_pipe.sv - scoreboard bench for rgb2binary_pipe
module tb_rgb2binary_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_de = 1'b0, in_hs = 1'b0, in_vs = 1'b0;
  logic [7:0]  in_r = '0, in_g = '0, in_b = '0;
  logic [7:0]  thr_lo = '0, thr_hi = '0;
  logic [1:0]  mode = '0;
  logic        out_de, out_hs, out_vs, out_flag, count_valid;
  logic [23:0] out_gray, out_binary;
  logic [19:0] white_count;

  always #5 clk = ~clk;

  rgb2binary_pipe #(.DW(8), .W_R(77), .W_G(150), .W_B(29), .CNT_W(20)) dut (
    .CLK(clk), .RST_N(rst_n),
    .IN_DE(in_de), .IN_HS(in_hs), .IN_VS(in_vs),
    .IN_R(in_r), .IN_G(in_g), .IN_B(in_b),
    .THRESHOLD_LO(thr_lo), .THRESHOLD_HI(thr_hi), .MODE(mode),
    .OUT_DE(out_de), .OUT_HS(out_hs), .OUT_VS(out_vs),
    .OUT_GRAY(out_gray), .OUT_FLAG(out_flag), .OUT_BINARY(out_binary),
    .WHITE_COUNT(white_count), .COUNT_VALID(count_valid)
  );

  typedef struct packed {
    logic        de, hs, vs;
    logic [23:0] gray;
    logic        flag;
    logic [23:0] bin;
    logic [19:0] wc;
    logic        cv;
  } exp_t;

  typedef struct {
    logic [7:0] r, g, b;
    logic [1:0] md;
    logic [7:0] lo, hi;
    logic [7:0] xg;
    logic       xf;
  } vec_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [1:0]  m_mode;
  logic [7:0]  m_lo, m_hi;
  logic        m_pend, m_prev_vs;
  logic [19:0] m_cnt, m_wc;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, want);
    end
  endtask

  function automatic logic [7:0] model_gray(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int s;
    s = (int'(r) * 77 + int'(g) * 150 + int'(b) * 29 + 128) >> 8;
    if (s > 255) s = 255;
    return s[7:0];
  endfunction

  task automatic check_out();
    exp_t e;
    if (q.size() >= 3) begin
      e = q.pop_front();
      cmp("de", 32'(out_de), 32'(e.de));
      cmp("hs", 32'(out_hs), 32'(e.hs));
      cmp("vs", 32'(out_vs), 32'(e.vs));
      cmp("gray", 32'(out_gray), 32'(e.gray));
      cmp("flag", 32'(out_flag), 32'(e.flag));
      cmp("binary", 32'(out_binary), 32'(e.bin));
      cmp("white_count", 32'(white_count), 32'(e.wc));
      cmp("count_valid", 32'(count_valid), 32'(e.cv));
    end
  endtask

  task automatic step(input logic rst, input logic de, input logic hs, input logic vs,
                      input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb,
                      input logic [1:0] md, input logic [7:0] lo, input logic [7:0] hi,
                      input bit use_exp = 1'b0, input logic [7:0] xg = 8'd0, input logic xf = 1'b0);
    exp_t       e;
    logic [7:0] g;
    logic       f, white, rise;
    @(negedge clk);
    check_out();
    rst_n = rst; in_de = de; in_hs = hs; in_vs = vs;
    in_r = pr; in_g = pg; in_b = pb; mode = md; thr_lo = lo; thr_hi = hi;
    if (!rst) begin
      m_mode = 2'd0; m_lo = 8'd0; m_hi = 8'd0; m_pend = 1'b1; m_prev_vs = 1'b0;
      m_cnt = '0; m_wc = '0;
      q.delete();
      e = '0;
      repeat (3) q.push_back(e);
    end else begin
      rise = vs && !m_prev_vs;
      if (m_pend || rise) begin
        m_mode = md; m_lo = lo; m_hi = hi; m_pend = 1'b0;
      end
      g = use_exp ? xg : model_gray(pr, pg, pb);
      case (m_mode)
        2'd1:    f = (g <= m_lo);
        2'd2:    f = (m_lo <= g) && (g <= m_hi);
        default: f = (g > m_lo);
      endcase
      if (use_exp) f = xf;
      e = '0;
      e.de = de; e.hs = hs; e.vs = vs;
      if (de) begin
        e.gray = {3{g}};
        e.flag = f;
        e.bin  = (m_mode == 2'd3) ? {3{g}} : {24{f}};
      end
`ifdef RGB2BIN_COUNT_EN
      white = de && f;
      if (rise) begin
        e.cv = 1'b1; e.wc = m_cnt; m_wc = m_cnt; m_cnt = 20'(white);
      end else begin
        e.cv = 1'b0; e.wc = m_wc;
        if (white && m_cnt != 20'hFFFFF) m_cnt = m_cnt + 20'd1;
      end
`else
      white = 1'b0;
      e.cv = white; e.wc = '0;
`endif
      m_prev_vs = vs;
      q.push_back(e);
    end
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{8'd255, 8'd0,   8'd0,   2'd0, 8'd100, 8'd0,  8'd77,  1'b0};
    vecs[1]  = '{8'd0,   8'd255, 8'd0,   2'd0, 8'd100, 8'd0,  8'd149, 1'b1};
    vecs[2]  = '{8'd0,   8'd0,   8'd255, 2'd0, 8'd100, 8'd0,  8'd29,  1'b0};
    vecs[3]  = '{8'd255, 8'd255, 8'd255, 2'd0, 8'd100, 8'd0,  8'd255, 1'b1};
    vecs[4]  = '{8'd200, 8'd200, 8'd200, 2'd0, 8'd100, 8'd0,  8'd200, 1'b1};
    vecs[5]  = '{8'd100, 8'd100, 8'd100, 2'd0, 8'd100, 8'd0,  8'd100, 1'b0};
    vecs[6]  = '{8'd101, 8'd101, 8'd101, 2'd0, 8'd100, 8'd0,  8'd101, 1'b1};
    vecs[7]  = '{8'd100, 8'd100, 8'd100, 2'd1, 8'd100, 8'd0,  8'd100, 1'b1};
    vecs[8]  = '{8'd50,  8'd50,  8'd50,  2'd2, 8'd50,  8'd60, 8'd50,  1'b1};
    vecs[9]  = '{8'd60,  8'd60,  8'd60,  2'd2, 8'd50,  8'd60, 8'd60,  1'b1};
    vecs[10] = '{8'd49,  8'd49,  8'd49,  2'd2, 8'd50,  8'd60, 8'd49,  1'b0};
    vecs[11] = '{8'd61,  8'd61,  8'd61,  2'd2, 8'd50,  8'd60, 8'd61,  1'b0};
    vecs[12] = '{8'd55,  8'd55,  8'd55,  2'd2, 8'd60,  8'd50, 8'd55,  1'b0};
    vecs[13] = '{8'd120, 8'd120, 8'd120, 2'd3, 8'd100, 8'd0,  8'd120, 1'b1};

    // reset, then a settling blank period
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 8'd100, 8'd0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 8'd100, 8'd0);

    // vector table: VS pulse loads settings, one visible pixel, one blank
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, vecs[i].md, vecs[i].lo, vecs[i].hi);
      step(1'b1, 1'b1, 1'(i % 2), 1'b0, vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].md, vecs[i].lo, vecs[i].hi,
           1'b1, vecs[i].xg, vecs[i].xf);
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, vecs[i].md, vecs[i].lo, vecs[i].hi);
    end

    // blanking: white pixels with DE low, HS toggling
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'(i % 2), 1'b0, 8'd255, 8'd255, 8'd255, 2'd0, 8'd100, 8'd0);

    // shadowing: lo raised mid-frame only takes effect after the next VS rise
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 2'd0, 8'd100, 8'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 8'd100, 8'd0);
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'd150, 8'd150, 8'd150, 2'd0, (i < 3) ? 8'd100 : 8'd200, 8'd0);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 8'd200, 8'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 2'd0, 8'd200, 8'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 2'd0, 8'd10, 8'd0);
    step(1'b1, 1'b0, 1'b0, 0, 8'd0, 8'd0, 8'd0, 2'd0, 8'd10, 8'd0);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'd150, 8'd150, 8'd150, 2'd0, 8'd10, 8'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 8'd10, 8'd0);

    // VS glitch: two loads, the second one wins
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 2'd0, 8'd30, 8'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 8'd30, 8'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 2'd0, 8'd40, 8'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 8'd0, 8'd0);
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'd35, 8'd35, 8'd35, 2'd0, 8'd0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 8'd0, 8'd0);

    // frame count: 37 white visible pixels, 10 white blanked pixels
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 2'd0, 8'd100, 8'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 8'd100, 8'd0);
    repeat (37) step(1'b1, 1'b1, 1'b0, 1'b0, 8'd255, 8'd255, 8'd255, 2'd0, 8'd100, 8'd0);
    repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0, 8'd255, 8'd255, 8'd255, 2'd0, 8'd100, 8'd0);
    repeat (2)  step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 8'd100, 8'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 2'd0, 8'd100, 8'd0);
    repeat (3)  step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 8'd100, 8'd0);

    // one-cycle reset in the middle of a visible stream
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 8'd150, 8'd150, 8'd150, 2'd0, 8'd100, 8'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd150, 8'd150, 8'd150, 2'd0, 8'd100, 8'd0);
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, 8'd150, 8'd150, 8'd150, 2'd0, 8'd100, 8'd0);

    // drain the pipeline
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 8'd100, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
